// File: rtl/exec_writeback_unit.sv
// Execute/write-back stage: single-cycle ALU ops plus optional shift-add multiply.
// Optional feature macro: EXEC_MUL_EN (16-cycle multiplier; otherwise MUL flags illegal).
module exec_writeback_unit #(
  parameter int W    = 16,
  parameter int RIDX = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [2:0]      op,
  input  logic [RIDX-1:0] rd_in,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            we,
  output logic [RIDX-1:0] rd,
  output logic [W-1:0]    wd,
  output logic            flag_z,
  output logic            flag_c,
  output logic            illegal,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
  } op_t;

  state_t         state;
  op_t            op_dec;
  logic           accept;
  logic [W-1:0]   alu_res;
  logic           alu_c;
  logic           alu_c_upd;
  logic [W:0]     sum_ext;
  logic [W:0]     diff_ext;

  assign op_dec   = op_t'(op);
  assign accept   = issue_valid & issue_ready;
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Extended-width difference: its top bit is exactly the unsigned borrow (a < b).
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_c_upd = 1'b0;
    unique case (op_dec)
      OP_ADD: begin
        alu_res   = sum_ext[W-1:0];
        alu_c     = sum_ext[W];
        alu_c_upd = 1'b1;
      end
      OP_SUB: begin
        alu_res   = diff_ext[W-1:0];
        alu_c     = diff_ext[W];
        alu_c_upd = 1'b1;
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  alu_res = a << b[3:0];
      OP_SHR:  alu_res = a >> b[3:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_next;
  logic [CNT_W-1:0] cnt;
  logic [RIDX-1:0]  rd_lat;

  assign acc_next    = b_sh[0] ? (acc + a_sh) : acc;
  assign issue_ready = (state != S_MUL);
`else
  assign issue_ready = 1'b1;
  assign busy        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      we      <= 1'b0;
      rd      <= '0;
      wd      <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      illegal <= 1'b0;
`ifdef EXEC_MUL_EN
      busy    <= 1'b0;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      rd_lat  <= '0;
`endif
    end else begin
      we      <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_MUL: begin
`ifdef EXEC_MUL_EN
          acc  <= acc_next;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state  <= S_WB;
            busy   <= 1'b0;
            we     <= 1'b1;
            rd     <= rd_lat;
            wd     <= acc_next;
            flag_z <= (acc_next == '0);
          end
`else
          state <= S_IDLE;
`endif
        end
        default: begin
          if (accept) begin
            if (op_dec == OP_MUL) begin
`ifdef EXEC_MUL_EN
              state  <= S_MUL;
              busy   <= 1'b1;
              a_sh   <= a;
              b_sh   <= b;
              acc    <= '0;
              cnt    <= '0;
              rd_lat <= rd_in;
`else
              state   <= S_IDLE;
              illegal <= 1'b1;
`endif
            end else begin
              state  <= S_WB;
              we     <= 1'b1;
              rd     <= rd_in;
              wd     <= alu_res;
              flag_z <= (alu_res == '0);
              if (alu_c_upd) flag_c <= alu_c;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
